// File: rtl/eth_rx_mac_filter.sv
// Ethernet RX destination-address filter on an 8-bit AXI-Stream path.
// Statistics (counters, drop_pulse) are built only with ETH_RX_FILTER_STATS_EN.
module eth_rx_mac_filter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic [47:0]          cfg_mac_addr,
    input  logic                 cfg_promisc,
    input  logic                 cfg_bcast_en,
    input  logic                 cfg_mcast_en,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] stat_accept_cnt,
    output logic [CNT_WIDTH-1:0] stat_drop_cnt,
    output logic                 drop_pulse
);
    typedef enum logic [1:0] {HDR, FWD_HDR, PASS, DROP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  rd_idx_q, rd_idx_d;
    logic [7:0]  hdr_buf_q [6];
    logic        en_q;
    logic        s_hs;
    logic [47:0] addr;
    logic        is_bcast;
    logic        match;
    logic        accept_evt;
    logic        drop_evt;

    assign s_hs = s_axis_tvalid & s_axis_tready;

    // Decision address: five buffered bytes plus the byte in flight.
    assign addr = {hdr_buf_q[0], hdr_buf_q[1], hdr_buf_q[2],
                   hdr_buf_q[3], hdr_buf_q[4], s_axis_tdata};
    assign is_bcast = (addr == 48'hFFFF_FFFF_FFFF);
    assign match = cfg_promisc
                 | (addr == cfg_mac_addr)
                 | (cfg_bcast_en & is_bcast)
                 | (cfg_mcast_en & hdr_buf_q[0][0] & ~is_bcast);

    // Hold off upstream until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= 1'b1;
    end

    // State register and byte indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HDR;
            idx_q    <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Capture destination-address bytes while collecting the header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) hdr_buf_q[i] <= '0;
        end else if (state_q == HDR && s_hs) begin
            hdr_buf_q[idx_q] <= s_axis_tdata;
        end
    end

    // Next-state logic and accept/drop decision events.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_idx_d   = rd_idx_q;
        accept_evt = 1'b0;
        drop_evt   = 1'b0;
        unique case (state_q)
            HDR: begin
                if (s_hs) begin
                    if (s_axis_tlast) begin
                        idx_d    = '0;
                        drop_evt = 1'b1;
                    end else if (idx_q == 3'd5) begin
                        idx_d = '0;
                        if (match) begin
                            state_d    = FWD_HDR;
                            accept_evt = 1'b1;
                        end else begin
                            state_d  = DROP;
                            drop_evt = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            FWD_HDR: begin
                if (m_axis_tready) begin
                    if (rd_idx_q == 3'd5) begin
                        rd_idx_d = '0;
                        state_d  = PASS;
                    end else begin
                        rd_idx_d = rd_idx_q + 3'd1;
                    end
                end
            end
            PASS: begin
                if (s_hs && s_axis_tlast) state_d = HDR;
            end
            DROP: begin
                if (s_hs && s_axis_tlast) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    // Stream outputs per state.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        unique case (state_q)
            HDR: s_axis_tready = en_q;
            FWD_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_buf_q[rd_idx_q];
            end
            PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
            end
            DROP: s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] drp_q, drp_d;
    logic                 pulse_q;

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        acc_d = acc_q;
        drp_d = drp_q;
        if (stat_clear) begin
            acc_d = '0;
            drp_d = '0;
        end else begin
            if (accept_evt && acc_q != '1) acc_d = acc_q + CNT_WIDTH'(1);
            if (drop_evt && drp_q != '1)   drp_d = drp_q + CNT_WIDTH'(1);
        end
    end

    // Counter and drop-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            drp_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            drp_q   <= drp_d;
            pulse_q <= drop_evt;
        end
    end

    assign stat_accept_cnt = acc_q;
    assign stat_drop_cnt   = drp_q;
    assign drop_pulse      = pulse_q;
`else
    logic unused_stats;
    assign unused_stats    = ^{stat_clear, accept_evt, drop_evt};
    assign stat_accept_cnt = '0;
    assign stat_drop_cnt   = '0;
    assign drop_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed self-checking bench for eth_rx_mac_filter.
// Counter expectations follow ETH_RX_FILTER_STATS_EN.
module tb_eth_rx_mac_filter;
    localparam int CW = 32;
`ifdef ETH_RX_FILTER_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif
    localparam logic [47:0] OWN = 48'h02_00_00_00_00_01;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [47:0]   cfg_mac_addr;
    logic          cfg_promisc;
    logic          cfg_bcast_en;
    logic          cfg_mcast_en;
    logic          stat_clear;
    logic [CW-1:0] stat_accept_cnt;
    logic [CW-1:0] stat_drop_cnt;
    logic          drop_pulse;

    logic tog_en = 1'b0;
    logic tog_q  = 1'b0;

    int checks   = 0;
    int failures = 0;

    eth_rx_mac_filter #(.CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .cfg_mac_addr    (cfg_mac_addr),
        .cfg_promisc     (cfg_promisc),
        .cfg_bcast_en    (cfg_bcast_en),
        .cfg_mcast_en    (cfg_mcast_en),
        .stat_clear      (stat_clear),
        .stat_accept_cnt (stat_accept_cnt),
        .stat_drop_cnt   (stat_drop_cnt),
        .drop_pulse      (drop_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tog_q <= ~tog_q;
    assign m_axis_tready = tog_en ? tog_q : 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    int         ncyc      = 0;
    int         vld_cnt   = 0;
    int         pulse_cnt = 0;
    int         stall_chk = 0;
    int         in_cyc[$];
    logic [7:0] rx_d[$];
    logic       rx_l[$];
    logic       rx_u[$];
    int         rx_cyc[$];
    logic       stall_q = 1'b0;
    logic [9:0] st_q    = '0;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (rst_n) begin
            if (stall_q) begin
                stall_chk++;
                chk("stall_hold",
                    64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                    64'({1'b1, st_q}));
            end
            if (s_axis_tvalid && s_axis_tready) in_cyc.push_back(ncyc);
            if (m_axis_tvalid) vld_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                rx_d.push_back(m_axis_tdata);
                rx_l.push_back(m_axis_tlast);
                rx_u.push_back(m_axis_tuser);
                rx_cyc.push_back(ncyc);
            end
            if (drop_pulse) pulse_cnt++;
        end
        stall_q = rst_n && m_axis_tvalid && !m_axis_tready;
        st_q    = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end

    function automatic bq_t mk(input logic [47:0] da, input int len,
                               input int seed);
        bq_t q;
        for (int i = 0; i < len; i++) begin
            if (i < 6) q.push_back(da[47-8*i -: 8]);
            else       q.push_back(8'(i * 3 + seed));
        end
        return q;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t b, input logic ulast,
                        input logic do_last, input logic clr6);
        int n;
        for (int i = 0; i < b.size(); i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b[i];
            s_axis_tlast  = do_last && (i == b.size() - 1);
            s_axis_tuser  = s_axis_tlast & ulast;
            stat_clear    = clr6 && (i == 5);
            n = 0;
            @(negedge clk);
            while (!s_axis_tready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout byte=%0d obs=stalled exp=accepted", i);
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = '0;
        stat_clear    = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input bq_t exp, input int base);
        int mism;
        int nl;
        int lpos;
        mism = 0;
        nl   = 0;
        lpos = -1;
        chk({tag, "_len"}, 64'(rx_d.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < rx_d.size()) begin
                if (rx_d[base+i] !== exp[i]) mism++;
                if (rx_l[base+i]) begin
                    nl++;
                    lpos = i;
                end
            end
        end
        chk({tag, "_data"}, 64'(mism), 64'(0));
        chk({tag, "_lastpos"}, 64'(lpos), 64'(exp.size() - 1));
        chk({tag, "_nlast"}, 64'(nl), 64'(1));
    endtask

    initial begin
        bq_t f;
        bq_t p;
        int  b0;
        int  i0;
        int  v0;
        int  p0;
        int  s0;

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        cfg_mac_addr  = OWN;
        cfg_promisc   = 1'b0;
        cfg_bcast_en  = 1'b0;
        cfg_mcast_en  = 1'b0;
        stat_clear    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_m_tdata",  64'(m_axis_tdata),  64'(0));
        chk("rst_m_tlast",  64'(m_axis_tlast),  64'(0));
        chk("rst_m_tuser",  64'(m_axis_tuser),  64'(0));
        chk("rst_pulse",    64'(drop_pulse),    64'(0));
        chk("rst_acc",      64'(stat_accept_cnt), 64'(0));
        chk("rst_drop",     64'(stat_drop_cnt),   64'(0));
        rst_n = 1'b1;
        #1;
        chk("rdy_before_clk", 64'(s_axis_tready), 64'(0));
        @(posedge clk);
        #1;
        chk("rdy_after_clk", 64'(s_axis_tready), 64'(1));

        // Own address, 64 bytes, latency of first output.
        b0 = rx_d.size();
        i0 = in_cyc.size();
        f  = mk(OWN, 64, 1);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk_frame("t1", f, b0);
        chk("t1_latency", 64'(rx_cyc[b0] - in_cyc[i0+5]), 64'(1));
        chk("t1_acc",  64'(stat_accept_cnt), 64'(ST * 1));
        chk("t1_drop", 64'(stat_drop_cnt),   64'(0));

        // Foreign unicast dropped.
        v0 = vld_cnt;
        i0 = in_cyc.size();
        p0 = pulse_cnt;
        f  = mk(48'h02_00_00_00_00_02, 64, 2);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t2_no_valid", 64'(vld_cnt - v0), 64'(0));
        chk("t2_consumed", 64'(in_cyc.size() - i0), 64'(64));
        chk("t2_drop",  64'(stat_drop_cnt), 64'(ST * 1));
        chk("t2_pulse", 64'(pulse_cnt - p0), 64'(ST * 1));

        // Broadcast: blocked with mcast only, passed with bcast_en.
        cfg_mcast_en = 1'b1;
        v0 = vld_cnt;
        f  = mk(48'hFF_FF_FF_FF_FF_FF, 20, 3);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t3_bc_blocked", 64'(vld_cnt - v0), 64'(0));
        chk("t3_bc_drop", 64'(stat_drop_cnt), 64'(ST * 2));
        cfg_bcast_en = 1'b1;
        b0 = rx_d.size();
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk_frame("t3_bc", f, b0);
        chk("t3_bc_acc", 64'(stat_accept_cnt), 64'(ST * 2));
        b0 = rx_d.size();
        f  = mk(48'h01_00_5E_00_00_01, 20, 4);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk_frame("t3_mc", f, b0);
        chk("t3_mc_acc", 64'(stat_accept_cnt), 64'(ST * 3));
        cfg_mcast_en = 1'b0;
        cfg_bcast_en = 1'b0;

        // Runt then a good frame.
        v0 = vld_cnt;
        p0 = pulse_cnt;
        f  = mk(OWN, 4, 5);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t4_runt_out", 64'(vld_cnt - v0), 64'(0));
        chk("t4_runt_drop", 64'(stat_drop_cnt), 64'(ST * 3));
        chk("t4_runt_pulse", 64'(pulse_cnt - p0), 64'(ST * 1));
        b0 = rx_d.size();
        f  = mk(OWN, 30, 6);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk_frame("t4_next", f, b0);
        chk("t4_acc", 64'(stat_accept_cnt), 64'(ST * 4));

        // Downstream back-pressure toggling, tuser on last byte.
        tog_en = 1'b1;
        s0 = stall_chk;
        b0 = rx_d.size();
        f  = mk(OWN, 24, 7);
        send(f, 1'b1, 1'b1, 1'b0);
        idle(3);
        tog_en = 1'b0;
        idle(1);
        chk_frame("t5", f, b0);
        chk("t5_tuser", 64'(rx_u[rx_u.size()-1]), 64'(1));
        chk("t5_stalled", 64'(stall_chk > s0), 64'(1));
        chk("t5_acc", 64'(stat_accept_cnt), 64'(ST * 5));

        // Reset in the middle of PASS.
        f = mk(OWN, 40, 8);
        p = f[0:9];
        send(p, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("t6_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t6_rst_m_tdata",  64'(m_axis_tdata),  64'(0));
        chk("t6_rst_acc",      64'(stat_accept_cnt), 64'(0));
        chk("t6_rst_drop",     64'(stat_drop_cnt),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b0 = rx_d.size();
        f  = mk(OWN, 20, 9);
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk_frame("t6", f, b0);
        chk("t6_acc", 64'(stat_accept_cnt), 64'(ST * 1));

        // Clear coinciding with an accept decision.
        f = mk(OWN, 20, 10);
        send(f, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("t7_clear_acc", 64'(stat_accept_cnt), 64'(0));
        chk("t7_clear_drop", 64'(stat_drop_cnt), 64'(0));
        send(f, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t7_acc_after", 64'(stat_accept_cnt), 64'(ST * 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/eth_rx_mac_filter.md
# eth_rx_mac_filter

Receive-path destination-address filter placed directly after the MAC RX FIFO output, in the logic clock domain. It accepts 8-bit AXI-Stream Ethernet frames (first byte = first destination-MAC byte) and buffers the 6-byte destination address. It then forwards the whole frame unchanged, or silently drops it, according to the station address and the promiscuous, broadcast and multicast enables. Optional saturating accept/drop counters report filter activity.

## Interface
- CNT_WIDTH, 32, width of statistics counters (only used with stats compiled in)
- clk  in  1  logic clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  8  frame byte from RX FIFO
- s_axis_tvalid  in  1  input byte valid
- s_axis_tready  out  1  input byte accepted when tvalid&tready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  bad-frame flag, valid with tlast
- m_axis_tdata  out  8  forwarded byte
- m_axis_tvalid  out  1  output byte valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last byte of forwarded frame
- m_axis_tuser  out  1  bad-frame flag, passed through with tlast
- cfg_mac_addr  in  48  station address; [47:40] is the first byte on the wire
- cfg_promisc  in  1  accept every frame of 7 or more bytes
- cfg_bcast_en  in  1  accept FF:FF:FF:FF:FF:FF
- cfg_mcast_en  in  1  accept any address with bit 0 of the first byte set, broadcast excluded
- stat_clear  in  1  synchronous clear of both counters
- stat_accept_cnt  out  CNT_WIDTH  frames accepted
- stat_drop_cnt  out  CNT_WIDTH  frames dropped, runts included
- drop_pulse  out  1  one-cycle pulse per dropped frame

## Operation
- States: HDR, FWD_HDR, PASS, DROP. Reset state HDR, byte index 0.
- **HDR**
  - s_axis_tready=1 and m_axis_tvalid=0.
  - Each accepted byte is stored in hdr_buf[idx] and idx increments.
  - If tlast is accepted while idx≤5, the frame is a runt: count a drop, pulse drop_pulse, clear idx, stay in HDR.
  - When the 6th byte (idx==5) is accepted without tlast, evaluate the match from the 5 stored bytes plus the current byte. Match = promisc | (addr==cfg_mac_addr) | (bcast_en & addr==all-ones) | (mcast_en & first-byte bit0 & addr!=all-ones).
  - Match → FWD_HDR with accept count +1. No match → DROP with drop count +1 and drop_pulse.
  - cfg_* is sampled only in this decision cycle.
- **FWD_HDR**
  - s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=hdr_buf[rd_idx], tlast=0, tuser=0.
  - rd_idx advances on m_axis_tready. After the 6th handshake, go to PASS.
- **PASS**
  - Combinational pass-through: m_axis_t{data,last,user}=s_axis_*, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - On a tlast handshake, go to HDR with idx=0.
- **DROP**
  - s_axis_tready=1, m_axis_tvalid=0. Accepted bytes are discarded.
  - On tlast accepted, go to HDR.
- m_axis outputs in FWD_HDR must hold stable while tvalid&!tready (AXI-Stream rule).
- Frames with tuser=1 are not filtered on tuser; the flag is forwarded as received.

## Timing
- Reset values: s_axis_tready=0 while rst_n low, then 1 from the first clk after release. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, drop_pulse=0, both counters 0.
- Latency: the first output byte is valid the cycle after the 6th input handshake. Header bytes then stream at 1/cycle with m_axis_tready held high. PASS adds zero cycles.
- Per-frame overhead: 6 cycles in FWD_HDR, during which input is stalled.
- drop_pulse is asserted in the cycle after the runt-tlast or no-match decision handshake.
- Counters saturate at 2^CNT_WIDTH−1. stat_clear has priority over a same-cycle increment, and the result is 0.
- Reset mid-frame returns to HDR immediately. Upstream is reset in the same domain; the bytes that follow are treated as a new frame start.

## Configuration
- ETH_RX_FILTER_STATS_EN
  - Defined: counters, stat_clear and drop_pulse are implemented as above.
  - Undefined: counter registers are not built. stat_accept_cnt, stat_drop_cnt and drop_pulse are tied to 0, and stat_clear is ignored. Filtering behaviour is identical.

## Test plan
- cfg_mac_addr=02:00:00:00:00:01, 64-byte frame to that address, m_axis_tready=1 → identical 64 bytes out, tlast on byte 64, accept_cnt=1, first output one cycle after 6th input.
- Same cfg, frame to 02:00:00:00:00:02 with promisc=0 → no m_axis_tvalid, 64 input bytes consumed, drop_cnt=1, one drop_pulse.
- Broadcast frame: with bcast_en=0 and mcast_en=1 → dropped. With bcast_en=1 → forwarded. Frame to 01:00:5E:00:00:01 with mcast_en=1 → forwarded.
- 4-byte runt with tlast on byte 4 → nothing out, drop_cnt +1. A following valid frame is forwarded intact.
- m_axis_tready toggling 1/0 each cycle through FWD_HDR and PASS, tuser=1 on last byte → byte order preserved, data stable while stalled, m_axis_tuser=1 with tlast.
- Assert rst_n low mid-PASS, then release and send a new frame → outputs return to reset values, idx=0, new frame filtered correctly. Then drive stat_clear with a simultaneous accept → counter reads 0.
